sram_port_arbiter: RTL and testbench

// - Shares the single external SRAM port between three requesters: VGA reader, decompressor

---
 rtl/sram_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Three-way arbiter for the single external SRAM port: VGA reads, decompressor read/write, UART writes.
// Optional grant/turnaround statistics are enabled by defining SRAM_ARB_STATS_EN.
module sram_port_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              VGA_req_i,
  input  logic [ADDR_W-1:0] VGA_addr_i,
  output logic              VGA_gnt_o,
  output logic              VGA_rvalid_o,
  output logic [DATA_W-1:0] VGA_rdata_o,
  input  logic              DEC_req_i,
  input  logic              DEC_we_i,
  input  logic [ADDR_W-1:0] DEC_addr_i,
  input  logic [DATA_W-1:0] DEC_wdata_i,
  output logic              DEC_gnt_o,
  output logic              DEC_rvalid_o,
  output logic [DATA_W-1:0] DEC_rdata_o,
  input  logic              UART_req_i,
  input  logic [ADDR_W-1:0] UART_addr_i,
  input  logic [DATA_W-1:0] UART_wdata_i,
  output logic              UART_gnt_o,
  output logic [ADDR_W-1:0] SRAM_address_o,
  output logic [DATA_W-1:0] SRAM_write_data_o,
  output logic              SRAM_we_n_o,
  input  logic [DATA_W-1:0] SRAM_read_data_i
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       VGA_cnt_o,
  output logic [15:0]       DEC_cnt_o,
  output logic [15:0]       UART_cnt_o,
  output logic [15:0]       TURN_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_READ,
    ARB_WRITE,
    ARB_TURN
  } arb_state_t;

  arb_state_t        state_reg;
  logic              ptr_uart_reg;

  logic              pick_vga;
  logic              pick_dec;
  logic              pick_uart;
  logic              cand_read;
  logic              hold;
  logic              grant_read;
  logic              grant_write;
  logic              grant_any;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  // Best candidate first (VGA, then DEC/UART by pointer), then veto it when the bus cannot take it.
  always_comb begin
    pick_vga  = 1'b0;
    pick_dec  = 1'b0;
    pick_uart = 1'b0;
    if (VGA_req_i) begin
      pick_vga = 1'b1;
    end else if (DEC_req_i && UART_req_i) begin
      pick_uart = ptr_uart_reg;
      pick_dec  = ~ptr_uart_reg;
    end else if (DEC_req_i) begin
      pick_dec = 1'b1;
    end else if (UART_req_i) begin
      pick_uart = 1'b1;
    end

    cand_read = pick_vga | (pick_dec & ~DEC_we_i);
    hold      = Reset || (state_reg == ARB_TURN) || ((state_reg == ARB_WRITE) && cand_read);

    VGA_gnt_o   = pick_vga & ~hold;
    DEC_gnt_o   = pick_dec & ~hold;
    UART_gnt_o  = pick_uart & ~hold;
    grant_read  = cand_read & ~hold;
    grant_write = ((pick_dec & DEC_we_i) | pick_uart) & ~hold;
    grant_any   = grant_read | grant_write;
  end

  always_comb begin
    issue_addr  = UART_addr_i;
    issue_wdata = UART_wdata_i;
    if (pick_vga) begin
      issue_addr  = VGA_addr_i;
      issue_wdata = UART_wdata_i;
    end else if (pick_dec) begin
      issue_addr  = DEC_addr_i;
      issue_wdata = DEC_wdata_i;
    end
  end

  // Arbiter FSM, round-robin pointer and the registered SRAM command.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg         <= ARB_IDLE;
      ptr_uart_reg      <= 1'b0;
      SRAM_address_o    <= '0;
      SRAM_write_data_o <= '0;
      SRAM_we_n_o       <= 1'b1;
    end else begin
      case (state_reg)
        ARB_TURN: state_reg <= ARB_IDLE;
        ARB_WRITE: begin
          if (cand_read)        state_reg <= ARB_TURN;
          else if (grant_write) state_reg <= ARB_WRITE;
          else                  state_reg <= ARB_IDLE;
        end
        default: begin
          if (grant_read)       state_reg <= ARB_READ;
          else if (grant_write) state_reg <= ARB_WRITE;
          else                  state_reg <= ARB_IDLE;
        end
      endcase

      if (DEC_gnt_o)       ptr_uart_reg <= 1'b1;
      else if (UART_gnt_o) ptr_uart_reg <= 1'b0;

      if (grant_any) begin
        SRAM_address_o <= issue_addr;
        SRAM_we_n_o    <= ~grant_write;
        if (grant_write) SRAM_write_data_o <= issue_wdata;
      end else begin
        SRAM_we_n_o <= 1'b1;
      end
    end
  end

  // Tag pipe: stage k holds the read that drove the SRAM address k cycles ago.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
    logic valid_reg;
    logic dec_reg;
    logic valid_next;
    logic dec_next;

    if (gi == 0) begin : g_head
      assign valid_next = grant_read;
      assign dec_next   = pick_dec;
    end else begin : g_body
      assign valid_next = g_tag[gi-1].valid_reg;
      assign dec_next   = g_tag[gi-1].dec_reg;
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        valid_reg <= 1'b0;
        dec_reg   <= 1'b0;
      end else begin
        valid_reg <= valid_next;
        dec_reg   <= dec_next;
      end
    end
  end

  logic ret_valid;
  logic ret_dec;
  assign ret_valid = g_tag[READ_LATENCY-1].valid_reg;
  assign ret_dec   = g_tag[READ_LATENCY-1].dec_reg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      VGA_rvalid_o <= 1'b0;
      DEC_rvalid_o <= 1'b0;
      VGA_rdata_o  <= '0;
      DEC_rdata_o  <= '0;
    end else begin
      VGA_rvalid_o <= ret_valid & ~ret_dec;
      DEC_rvalid_o <= ret_valid & ret_dec;
      if (ret_valid && !ret_dec) VGA_rdata_o <= SRAM_read_data_i;
      if (ret_valid && ret_dec)  DEC_rdata_o <= SRAM_read_data_i;
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [3:0] stat_inc;
  assign stat_inc = {(state_reg == ARB_TURN), UART_gnt_o, DEC_gnt_o, VGA_gnt_o};

  // Saturating event counters: VGA, DEC, UART grants and TURN cycles.
  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge Clock) begin
      if (Reset) begin
        cnt_reg <= '0;
      end else if (stat_inc[gi] && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
  end

  assign VGA_cnt_o  = g_stat[0].cnt_reg;
  assign DEC_cnt_o  = g_stat[1].cnt_reg;
  assign UART_cnt_o = g_stat[2].cnt_reg;
  assign TURN_cnt_o = g_stat[3].cnt_reg;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM emulator, rule-level reference model with per-cycle compare,
// and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  localparam int RL = 2;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          VGA_req, DEC_req, DEC_we, UART_req;
  logic [AW-1:0] VGA_addr, DEC_addr, UART_addr;
  logic [DW-1:0] DEC_wdata, UART_wdata;
  logic          VGA_gnt_o, DEC_gnt_o, UART_gnt_o;
  logic          VGA_rvalid_o, DEC_rvalid_o;
  logic [DW-1:0] VGA_rdata_o, DEC_rdata_o;
  logic [AW-1:0] SRAM_address_o;
  logic [DW-1:0] SRAM_write_data_o;
  logic          SRAM_we_n_o;
  logic [DW-1:0] SRAM_read_data_i;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]   VGA_cnt_o, DEC_cnt_o, UART_cnt_o, TURN_cnt_o;
`endif

  sram_port_arbiter #(.READ_LATENCY(RL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clock(clk), .Reset(rst),
    .VGA_req_i(VGA_req), .VGA_addr_i(VGA_addr), .VGA_gnt_o(VGA_gnt_o),
    .VGA_rvalid_o(VGA_rvalid_o), .VGA_rdata_o(VGA_rdata_o),
    .DEC_req_i(DEC_req), .DEC_we_i(DEC_we), .DEC_addr_i(DEC_addr), .DEC_wdata_i(DEC_wdata),
    .DEC_gnt_o(DEC_gnt_o), .DEC_rvalid_o(DEC_rvalid_o), .DEC_rdata_o(DEC_rdata_o),
    .UART_req_i(UART_req), .UART_addr_i(UART_addr), .UART_wdata_i(UART_wdata), .UART_gnt_o(UART_gnt_o),
    .SRAM_address_o(SRAM_address_o), .SRAM_write_data_o(SRAM_write_data_o),
    .SRAM_we_n_o(SRAM_we_n_o), .SRAM_read_data_i(SRAM_read_data_i)
`ifdef SRAM_ARB_STATS_EN
    , .VGA_cnt_o(VGA_cnt_o), .DEC_cnt_o(DEC_cnt_o), .UART_cnt_o(UART_cnt_o), .TURN_cnt_o(TURN_cnt_o)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM emulator: data for the address driven one cycle earlier, writes land at the edge.
  logic [15:0]   sram_mem [256];
  logic [AW-1:0] addr_d;
  logic          mem_init;
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 256; i++) sram_mem[i] <= 16'hC000 | 16'(i);
    else if (!SRAM_we_n_o) sram_mem[SRAM_address_o[7:0]] <= SRAM_write_data_o;
    addr_d <= SRAM_address_o;
  end
  assign SRAM_read_data_i = sram_mem[addr_d[7:0]];

  // Reference model state.
  typedef struct { int due; bit dec; logic [15:0] data; } ret_t;
  ret_t          ret_q[$];
  logic [15:0]   shadow [256];
  bit            sh_init = 1'b0;
  int            m_ptr = 2;
  bit            m_last_wr = 1'b0;
  bit            m_turn = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic          m_we_n = 1'b1;
  logic [DW-1:0] m_wdata = '0;
  int            m_cnt [4] = '{0, 0, 0, 0};
  logic [15:0]   vga_rx[$], dec_rx[$];
  int            vga_rx_cyc[$];

  always @(negedge clk) begin : compare
    int best;
    bit best_rd;
    int g;
    bit new_turn;
    logic [2:0] exp_gnt;
    logic [1:0] exp_rv;
    ret_t r, r2;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    bit b_we;

    if (!sh_init) begin
      for (int i = 0; i < 256; i++) shadow[i] = 16'hC000 | 16'(i);
      sh_init = 1'b1;
    end

    best = 0;
    if (VGA_req) best = 1;
    else if (DEC_req && (!UART_req || m_ptr == 2)) best = 2;
    else if (UART_req) best = 3;
    best_rd = (best == 1) || (best == 2 && !DEC_we);
    g = (rst || m_turn || (m_last_wr && best_rd)) ? 0 : best;
    exp_gnt = {g == 1, g == 2, g == 3};
    check("gnt", {29'd0, VGA_gnt_o, DEC_gnt_o, UART_gnt_o}, {29'd0, exp_gnt});

    exp_rv = 2'b00;
    r = '{0, 1'b0, 16'h0};
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      r = ret_q.pop_front();
      exp_rv = r.dec ? 2'b01 : 2'b10;
    end
    check("rvalid", {30'd0, VGA_rvalid_o, DEC_rvalid_o}, {30'd0, exp_rv});
    if (exp_rv == 2'b10) check("vga_rdata", {16'd0, VGA_rdata_o}, {16'd0, r.data});
    if (exp_rv == 2'b01) check("dec_rdata", {16'd0, DEC_rdata_o}, {16'd0, r.data});
    if (VGA_rvalid_o) begin vga_rx.push_back(VGA_rdata_o); vga_rx_cyc.push_back(cyc); end
    if (DEC_rvalid_o) dec_rx.push_back(DEC_rdata_o);

    check("sram_we_n", {31'd0, SRAM_we_n_o}, {31'd0, m_we_n});
    check("sram_addr", {14'd0, SRAM_address_o}, {14'd0, m_addr});
    if (!m_we_n) check("sram_wdata", {16'd0, SRAM_write_data_o}, {16'd0, m_wdata});
`ifdef SRAM_ARB_STATS_EN
    check("vga_cnt",  {16'd0, VGA_cnt_o},  m_cnt[0]);
    check("dec_cnt",  {16'd0, DEC_cnt_o},  m_cnt[1]);
    check("uart_cnt", {16'd0, UART_cnt_o}, m_cnt[2]);
    check("turn_cnt", {16'd0, TURN_cnt_o}, m_cnt[3]);
`endif

    b_addr = UART_addr; b_data = UART_wdata; b_we = 1'b1;
    if (g == 1) begin b_addr = VGA_addr; b_we = 1'b0; end
    if (g == 2) begin b_addr = DEC_addr; b_data = DEC_wdata; b_we = DEC_we; end

    if (rst) begin
      m_ptr = 2; m_last_wr = 1'b0; m_turn = 1'b0; ret_q.delete();
      m_addr = '0; m_we_n = 1'b1; m_wdata = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      if (g != 0 && m_cnt[g-1] < 65535) m_cnt[g-1]++;
      if (m_turn && m_cnt[3] < 65535) m_cnt[3]++;
      new_turn = !m_turn && m_last_wr && best_rd;
      if (g != 0) begin
        m_addr = b_addr;
        m_we_n = !b_we;
        if (b_we) begin
          m_wdata = b_data;
          shadow[b_addr[7:0]] = b_data;
        end else begin
          r2.due = cyc + 1 + RL; r2.dec = (g == 2); r2.data = shadow[b_addr[7:0]];
          ret_q.push_back(r2);
        end
        if (g == 2) m_ptr = 3;
        if (g == 3) m_ptr = 2;
      end else begin
        m_we_n = 1'b1;
      end
      m_last_wr = (g != 0) && b_we;
      m_turn = new_turn;
    end
  end

  // Requester agents: queued transfers, head held until granted.
  typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } txn_t;
  txn_t vga_q[$], dec_q[$], uart_q[$];
  logic g_v, g_d, g_u;
  int   g_cyc;
  int   grant_log[$];

  function automatic txn_t mk(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    return t;
  endfunction

  task automatic drive();
    VGA_req = (vga_q.size() != 0);
    VGA_addr = VGA_req ? vga_q[0].addr : '0;
    DEC_req = (dec_q.size() != 0);
    DEC_we = DEC_req ? dec_q[0].we : 1'b0;
    DEC_addr = DEC_req ? dec_q[0].addr : '0;
    DEC_wdata = DEC_req ? dec_q[0].data : '0;
    UART_req = (uart_q.size() != 0);
    UART_addr = UART_req ? uart_q[0].addr : '0;
    UART_wdata = UART_req ? uart_q[0].data : '0;
  endtask

  task automatic tick();
    @(negedge clk);
    g_v = VGA_gnt_o; g_d = DEC_gnt_o; g_u = UART_gnt_o; g_cyc = cyc;
    if (g_v) grant_log.push_back(1);
    if (g_d) grant_log.push_back(2);
    if (g_u) grant_log.push_back(3);
    @(posedge clk);
    #1;
    if (g_v && vga_q.size() != 0) void'(vga_q.pop_front());
    if (g_d && dec_q.size() != 0) void'(dec_q.pop_front());
    if (g_u && uart_q.size() != 0) void'(uart_q.pop_front());
    drive();
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((vga_q.size() + dec_q.size() + uart_q.size() + ret_q.size()) != 0 && n < max) begin
      tick();
      n++;
    end
    check("idle_budget", {31'd0, n < max}, 32'd1);
    repeat (2) tick();
  endtask

  task automatic check_log(input string name, input int e0, input int e1, input int e2, input int e3, input int len);
    int e [4];
    e = '{e0, e1, e2, e3};
    check({name, "_len"}, grant_log.size(), len);
    for (int i = 0; i < len; i++)
      if (i < grant_log.size()) check(name, grant_log[i], e[i]);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stim
    int first, c0, n;
    rst = 1'b1; mem_init = 1'b1;
    drive();
    repeat (3) tick();
    check("reset_we_n", {31'd0, SRAM_we_n_o}, 32'd1);
    check("reset_addr", {14'd0, SRAM_address_o}, 32'd0);
    check("reset_rvalid", {30'd0, VGA_rvalid_o, DEC_rvalid_o}, 32'd0);
    check("reset_rdata", {VGA_rdata_o, DEC_rdata_o}, 32'd0);
    rst = 1'b0; mem_init = 1'b0;

    // Lone VGA burst
    for (int i = 0; i < 4; i++) vga_q.push_back(mk(1'b0, 18'(i), 16'h0));
    vga_rx.delete(); vga_rx_cyc.delete();
    drive();
    first = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_vga_gnt", {31'd0, g_v}, 32'd1);
      if (i == 0) first = g_cyc;
    end
    run_idle(50);
    check("t1_rx_count", vga_rx.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < vga_rx.size()) begin
        check("t1_rx_data", {16'd0, vga_rx[i]}, 32'hC000 + i);
        check("t1_rx_cycle", vga_rx_cyc[i] - first, 3 + i);
      end
    $display("t1 lone VGA burst done");

    // DEC/UART contention alternates, starting with DEC
    dec_q.push_back(mk(1'b1, 18'h20, 16'hD020));
    dec_q.push_back(mk(1'b1, 18'h21, 16'hD021));
    uart_q.push_back(mk(1'b1, 18'h30, 16'hA030));
    uart_q.push_back(mk(1'b1, 18'h31, 16'hA031));
    grant_log.delete();
    drive();
    run_idle(50);
    check_log("t2_order", 2, 3, 2, 3, 4);
    $display("t2 round robin done");

    // All three at once: VGA first, pointer untouched
    vga_q.push_back(mk(1'b0, 18'h05, 16'h0));
    dec_q.push_back(mk(1'b1, 18'h40, 16'hD040));
    uart_q.push_back(mk(1'b1, 18'h41, 16'hA041));
    grant_log.delete();
    drive();
    run_idle(50);
    check_log("t3_order", 1, 2, 3, 0, 3);
    $display("t3 VGA priority done");

    // Write then read: turnaround
    uart_q.push_back(mk(1'b1, 18'h10, 16'h1234));
    drive();
    tick();
    check("t4_uart_gnt", {31'd0, g_u}, 32'd1);
    c0 = g_cyc;
    dec_q.push_back(mk(1'b0, 18'h10, 16'h0));
    dec_rx.delete();
    drive();
    n = 0;
    do begin tick(); n++; end while (!g_d && n < 10);
    check("t4_dec_gnt_seen", {31'd0, g_d}, 32'd1);
    check("t4_turn_gap", g_cyc - c0, 32'd3);
    run_idle(50);
    check("t4_rx_count", dec_rx.size(), 32'd1);
    if (dec_rx.size() > 0) check("t4_rx_data", {16'd0, dec_rx[0]}, 32'h1234);
    $display("t4 turnaround done");

    // Reset with two reads in flight
    vga_q.push_back(mk(1'b0, 18'h06, 16'h0));
    vga_q.push_back(mk(1'b0, 18'h07, 16'h0));
    drive();
    tick(); check("t5_gnt0", {31'd0, g_v}, 32'd1);
    tick(); check("t5_gnt1", {31'd0, g_v}, 32'd1);
    rst = 1'b1;
    dec_q.push_back(mk(1'b0, 18'h08, 16'h0));
    vga_rx.delete();
    drive();
    tick();
    check("t5_gnt_in_reset", {29'd0, g_v, g_d, g_u}, 32'd0);
    check("t5_we_n", {31'd0, SRAM_we_n_o}, 32'd1);
    check("t5_addr", {14'd0, SRAM_address_o}, 32'd0);
`ifdef SRAM_ARB_STATS_EN
    check("t5_cnt", {VGA_cnt_o | DEC_cnt_o | UART_cnt_o | TURN_cnt_o}, 32'd0);
`endif
    rst = 1'b0;
    run_idle(50);
    check("t5_no_stale_rvalid", vga_rx.size(), 32'd0);
    $display("t5 reset mid-flight done");

    // Mixed traffic, two turnarounds
    vga_q.push_back(mk(1'b0, 18'h01, 16'h0));
    vga_q.push_back(mk(1'b0, 18'h02, 16'h0));
    dec_q.push_back(mk(1'b0, 18'h20, 16'h0));
    dec_q.push_back(mk(1'b1, 18'h50, 16'hD050));
    dec_q.push_back(mk(1'b0, 18'h50, 16'h0));
    uart_q.push_back(mk(1'b1, 18'h60, 16'hA060));
    uart_q.push_back(mk(1'b1, 18'h21, 16'hA021));
    vga_rx.delete(); dec_rx.delete();
    drive();
    run_idle(100);
    check("t6_vga_count", vga_rx.size(), 32'd2);
    if (vga_rx.size() == 2) begin
      check("t6_vga0", {16'd0, vga_rx[0]}, 32'hC001);
      check("t6_vga1", {16'd0, vga_rx[1]}, 32'hC002);
    end
    check("t6_dec_count", dec_rx.size(), 32'd2);
    if (dec_rx.size() == 2) begin
      check("t6_dec0", {16'd0, dec_rx[0]}, 32'hD020);
      check("t6_dec1", {16'd0, dec_rx[1]}, 32'hD050);
    end
    $display("t6 mixed traffic done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
